// File: rtl/gcd_sched_pkg.sv
// Shared constants for the GCD job scheduler: FSM encodings, operand and counter widths.
// Latency: n/a (constants only).
// Backpressure: n/a.
package gcd_sched_pkg;

  // Operand / result width of the shared GCD engine
  localparam int OPW = 8;

  // Default watchdog limit (RUN cycles) and job cycle counter width
  localparam int DEF_MAX_CYCLES = 1024;
  localparam int DEF_CW         = 16;

  // One-hot scheduler states
  localparam int ST_W = 6;
  localparam logic [5:0] ST_IDLE    = 6'b000001;
  localparam logic [5:0] ST_LOAD    = 6'b000010;
  localparam logic [5:0] ST_RUN     = 6'b000100;
  localparam logic [5:0] ST_ACK     = 6'b001000;
  localparam logic [5:0] ST_RESP    = 6'b010000;
  localparam logic [5:0] ST_RECOVER = 6'b100000;

endpackage

// File: rtl/gcd_job_scheduler_rr_arbiter.sv
// N-way round-robin picker: first set req bit at or after ptr, wrapping.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when a grant is consumed.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  // Rotating-priority search starting at ptr
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!gnt_vld && req[(int'(ptr) + k) % N]) begin
        gnt_vld                    = 1'b1;
        gnt[(int'(ptr) + k) % N]   = 1'b1;
        gnt_idx                    = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/gcd_job_scheduler.sv
// Shares one GCD engine between N_REQ requesters with round-robin grant, watchdog and soft reset.
// Latency: grant to resp_valid = load handshake + engine steps + ack handshake + 1; zero operands answer 1 cycle after grant.
// Backpressure: req is a level held until resp_valid; arbitration is skipped for one cycle after each response.
module gcd_job_scheduler
  import gcd_sched_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int IDW        = 2,
  parameter int MAX_CYCLES = DEF_MAX_CYCLES,
  parameter int CW         = DEF_CW
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [OPW*N_REQ-1:0] req_a,
  input  logic [OPW*N_REQ-1:0] req_b,
  input  logic                 step_en,
  output logic [N_REQ-1:0]     resp_valid,
  output logic [OPW-1:0]       resp_gcd,
  output logic                 resp_err,
  output logic [CW-1:0]        resp_cycles,
  output logic                 busy,
  output logic [IDW-1:0]       owner,
  output logic                 eng_start,
  output logic                 eng_ack,
  output logic                 eng_cen,
  output logic [OPW-1:0]       eng_ain,
  output logic [OPW-1:0]       eng_bin,
  output logic                 eng_reset,
  input  logic                 eng_q_i,
  input  logic                 eng_q_done,
  input  logic [OPW-1:0]       eng_gcd
);

  // Last RUN cycle before the watchdog fires
  localparam logic [CW-1:0] WD_LAST = CW'(MAX_CYCLES - 1);

  logic [ST_W-1:0]  state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d, owner_q, owner_d;
  logic [OPW-1:0]   ain_q, ain_d, bin_q, bin_d, gcd_q, gcd_d;
  logic [CW-1:0]    cyc_q, cyc_d, run_q, run_d, cyc_inc;
  logic [N_REQ-1:0] vld_q, vld_d;
  logic             err_q, err_d, start_q, start_d, ack_q, ack_d, cen_q, cen_d;
  logic             ereset_q, ereset_d, busy_q, busy_d, hold_q, hold_d;

  logic [N_REQ-1:0] gnt;
  logic [IDW-1:0]   gnt_idx, ptr_nxt;
  logic             gnt_vld;
  logic [OPW-1:0]   sel_a, sel_b;

  rr_arbiter #(.N(N_REQ), .IW(IDW)) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // Operand mux driven by the one-hot grant; next pointer is winner+1 with wrap
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_a |= req_a[OPW*i +: OPW];
        sel_b |= req_b[OPW*i +: OPW];
      end
    end
    ptr_nxt = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + IDW'(1);
  end

  // Job sequencing: grant, engine start handshake, run with watchdog, ack/recover, respond
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    ain_d    = ain_q;
    bin_d    = bin_q;
    gcd_d    = gcd_q;
    err_d    = err_q;
    cyc_d    = cyc_q;
    run_d    = run_q;
    vld_d    = '0;
    start_d  = start_q;
    ack_d    = ack_q;
    cen_d    = 1'b0;
    ereset_d = 1'b0;
    hold_d   = hold_q;
    cyc_inc  = (cyc_q == '1) ? cyc_q : cyc_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (hold_q) begin
          // Give the just-served requester time to drop its req
          hold_d = 1'b0;
        end else if (gnt_vld) begin
          owner_d = gnt_idx;
          ain_d   = sel_a;
          bin_d   = sel_b;
          ptr_d   = ptr_nxt;
          gcd_d   = '0;
          cyc_d   = '0;
          run_d   = '0;
          if (sel_a == '0 || sel_b == '0) begin
            // The engine never terminates on a zero operand: fail without touching it
            err_d   = 1'b1;
            vld_d   = N_REQ'(1) << gnt_idx;
            state_d = ST_RESP;
          end else begin
            err_d   = 1'b0;
            start_d = 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        cyc_d = cyc_inc;
        if (!eng_q_i) begin
          start_d = 1'b0;
          cen_d   = step_en;
          run_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cyc_d = cyc_inc;
        run_d = run_q + 1'b1;
        cen_d = step_en;
        if (eng_q_done) begin
          gcd_d   = eng_gcd;
          cen_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = ST_ACK;
        end else if (run_q == WD_LAST) begin
          err_d    = 1'b1;
          gcd_d    = '0;
          cen_d    = 1'b0;
          ereset_d = 1'b1;
          state_d  = ST_RECOVER;
        end
      end
      ST_ACK: begin
        if (eng_q_i) begin
          ack_d   = 1'b0;
          vld_d   = N_REQ'(1) << owner_q;
          state_d = ST_RESP;
        end
      end
      ST_RECOVER: begin
        if (eng_q_i) begin
          vld_d   = N_REQ'(1) << owner_q;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        hold_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; engine held in reset while the scheduler is
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      ain_q    <= '0;
      bin_q    <= '0;
      gcd_q    <= '0;
      err_q    <= 1'b0;
      cyc_q    <= '0;
      run_q    <= '0;
      vld_q    <= '0;
      start_q  <= 1'b0;
      ack_q    <= 1'b0;
      cen_q    <= 1'b0;
      ereset_q <= 1'b1;
      busy_q   <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      ain_q    <= ain_d;
      bin_q    <= bin_d;
      gcd_q    <= gcd_d;
      err_q    <= err_d;
      cyc_q    <= cyc_d;
      run_q    <= run_d;
      vld_q    <= vld_d;
      start_q  <= start_d;
      ack_q    <= ack_d;
      cen_q    <= cen_d;
      ereset_q <= ereset_d;
      busy_q   <= busy_d;
      hold_q   <= hold_d;
    end
  end

  assign resp_valid  = vld_q;
  assign resp_gcd    = gcd_q;
  assign resp_err    = err_q;
  assign resp_cycles = cyc_q;
  assign busy        = busy_q;
  assign owner       = owner_q;
  assign eng_start   = start_q;
  assign eng_ack     = ack_q;
  assign eng_cen     = cen_q;
  assign eng_ain     = ain_q;
  assign eng_bin     = bin_q;
  assign eng_reset   = ereset_q;

endmodule

// File: tb/tb_gcd_job_scheduler.sv
// Bench for gcd_job_scheduler with a behavioural GCD engine and a round-robin job model.
// Latency: n/a.
// Backpressure: requesters hold req until their response pulse, then drop it.
module tb_gcd_job_scheduler;
  import gcd_sched_pkg::*;

  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int MAXC = 20;
  localparam int CWT = 16;

  logic           Clk, Reset;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_a, req_b;
  logic           step_en;
  logic [N-1:0]   resp_valid;
  logic [7:0]     resp_gcd;
  logic           resp_err;
  logic [CWT-1:0] resp_cycles;
  logic           busy;
  logic [IW-1:0]  owner;
  logic           eng_start, eng_ack, eng_cen, eng_reset, eng_q_i, eng_q_done;
  logic [7:0]     eng_ain, eng_bin, eng_gcd;

  gcd_job_scheduler #(.N_REQ(N), .IDW(IW), .MAX_CYCLES(MAXC), .CW(CWT)) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .req_a(req_a), .req_b(req_b), .step_en(step_en),
    .resp_valid(resp_valid), .resp_gcd(resp_gcd), .resp_err(resp_err), .resp_cycles(resp_cycles),
    .busy(busy), .owner(owner), .eng_start(eng_start), .eng_ack(eng_ack), .eng_cen(eng_cen),
    .eng_ain(eng_ain), .eng_bin(eng_bin), .eng_reset(eng_reset), .eng_q_i(eng_q_i),
    .eng_q_done(eng_q_done), .eng_gcd(eng_gcd)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural subtract-based GCD engine: I -> SUB -> MULT -> DONE -> I
  logic [1:0] est;
  logic [7:0] ea, eb;
  always @(posedge Clk or posedge eng_reset) begin
    if (eng_reset) begin
      est <= 2'd0;
      ea  <= 8'd0;
      eb  <= 8'd0;
    end else begin
      case (est)
        2'd0: if (eng_start) begin ea <= eng_ain; eb <= eng_bin; est <= 2'd1; end
        2'd1: if (eng_cen) begin
                if (ea == eb) est <= 2'd2;
                else if (ea > eb) ea <= ea - eb;
                else eb <= eb - ea;
              end
        2'd2: if (eng_cen) est <= 2'd3;
        default: if (eng_ack) est <= 2'd0;
      endcase
    end
  end
  assign eng_q_i    = (est == 2'd0);
  assign eng_q_done = (est == 2'd3);
  assign eng_gcd    = ea;

  // Event counters observed by the checks
  int n_start, n_ereset, n_resp;
  initial begin n_start = 0; n_ereset = 0; n_resp = 0; end
  always @(posedge Clk) begin
    if (eng_start) n_start++;
    if (eng_reset && !Reset) n_ereset++;
    if (resp_valid != '0) n_resp++;
  end

  int n_tests, n_fail, last_cyc, waited;
  bit tog;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int ref_gcd(input int a, input int b);
    int x, y, t;
    x = a; y = b;
    if (x == 0 || y == 0) return 0;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic set_job(input int i, input int a, input int b);
    req_a[8*i +: 8] = a[7:0];
    req_b[8*i +: 8] = b[7:0];
  endtask

  // Wait for a response, check it, then drop the owner's req one cycle later
  task automatic serve(input int o, input int g, input bit e);
    bit got;
    got = 0;
    waited = 0;
    while (!got && waited < 400) begin
      @(negedge Clk);
      waited++;
      if (tog) step_en = ~step_en;
      if (resp_valid != '0) got = 1;
    end
    chk("resp_seen", {31'd0, got}, 1);
    if (got) begin
      chk("resp_owner", resp_valid, 32'd1 << o);
      chk("resp_gcd", resp_gcd, g);
      chk("resp_err", resp_err, e);
      if (!e) chk("resp_cycles_nz", resp_cycles != '0, 1);
      last_cyc = resp_cycles;
      @(negedge Clk);
      chk("pulse_width", resp_valid, 0);
      req[o] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    req = '0;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  int c1, nd, nr, mptr, o;
  logic [N-1:0] pend;
  logic [7:0] ra [N];
  logic [7:0] rb [N];

  initial begin
    n_tests = 0; n_fail = 0; tog = 0;
    Reset = 1'b1; req = '0; req_a = '0; req_b = '0; step_en = 1'b1;
    repeat (2) @(negedge Clk);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_eng_reset", eng_reset, 1);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_eng_ain", eng_ain, 0);
    chk("rst_resp_cycles", resp_cycles, 0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("eng_reset_release", eng_reset, 0);

    // Single job on requester 0
    set_job(0, 12, 18); req = 4'b0001;
    serve(0, 6, 0);

    // Two simultaneous requests; requester 0 re-requests right after its answer
    do_reset();
    set_job(0, 48, 36); set_job(2, 8, 8); req = 4'b0101;
    serve(0, 12, 0);
    req[0] = 1'b1;
    serve(2, 8, 0);
    serve(0, 12, 0);

    // Zero operand: fast error, engine never started
    nd = n_start;
    set_job(1, 0, 9); req = 4'b0010;
    serve(1, 0, 1);
    chk("zero_latency_ok", waited <= 2, 1);
    chk("zero_cycles", last_cyc, 0);
    chk("zero_no_start", n_start - nd, 0);

    // Watchdog with the engine stalled, then the same job completes
    nd = n_ereset;
    step_en = 1'b0;
    set_job(3, 6, 4); req = 4'b1000;
    serve(3, 0, 1);
    chk("wd_ereset_once", n_ereset - nd, 1);
    step_en = 1'b1;
    req = 4'b1000;
    serve(3, 2, 0);

    // Toggled step enable runs slower than constant stepping
    set_job(2, 40, 24); req = 4'b0100;
    serve(2, 8, 0);
    c1 = last_cyc;
    tog = 1; req = 4'b0100;
    serve(2, 8, 0);
    tog = 0; step_en = 1'b1;
    chk("toggle_slower", last_cyc > c1, 1);

    // Reset in the middle of RUN aborts silently
    do_reset();
    set_job(0, 200, 1); req = 4'b0001;
    repeat (6) @(negedge Clk);
    chk("busy_mid_run", busy, 1);
    nr = n_resp;
    Reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_eng_reset", eng_reset, 1);
    chk("abort_resp_valid", resp_valid, 0);
    req = '0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (4) @(negedge Clk);
    chk("abort_no_resp", n_resp - nr, 0);
    set_job(0, 9, 6); req = 4'b0001;
    serve(0, 3, 0);

    // Random rounds against the round-robin model
    do_reset();
    mptr = 0;
    for (int r = 0; r < 8; r++) begin
      pend = N'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        int g;
        g = $urandom_range(1, 40);
        ra[i] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'(g * $urandom_range(1, 6));
        rb[i] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'(g * $urandom_range(1, 6));
        set_job(i, ra[i], rb[i]);
      end
      req = pend;
      while (pend != '0) begin
        o = rr_pick(pend, mptr);
        mptr = (o + 1) % N;
        serve(o, ref_gcd(ra[o], rb[o]), (ra[o] == 0 || rb[o] == 0));
        pend[o] = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
